// File: rtl/uart_program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_program_loader_pkg;

   localparam int unsigned BAUD_COUNT_CHECK      = 868;
   localparam int unsigned PROGRAM_ADDRESS_WIDTH = 8;
   localparam int unsigned INSTRUCTION_WIDTH     = 32;
   localparam int unsigned NUM_DATA_BITS         = 8;
   localparam int unsigned PROGRAM_WORDS         = 2**(PROGRAM_ADDRESS_WIDTH-2);

   localparam logic [INSTRUCTION_WIDTH-1:0] NOOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      L_IDLE,
      L_LOAD,
      L_CHECK,
      L_PAD,
      L_DONE
   } loader_state_type;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_type;

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
module uart_rx
   import uart_program_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = BAUD_COUNT_CHECK
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_i,
   output logic [NUM_DATA_BITS-1:0] byte_o,
   output logic                     valid_o,
   output logic                     frame_err_o
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned BW   = $clog2(NUM_DATA_BITS);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;

   uart_rx_state_type r_state, w_state_nxt;
   logic                     r_sync1, r_sync2, r_rx_prev;
   logic [CW-1:0]            r_baud, w_baud_nxt;
   logic [BW-1:0]            r_bit, w_bit_nxt;
   logic [NUM_DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                     r_valid, w_valid_nxt;
   logic                     r_ferr, w_ferr_nxt;
   logic                     w_fall;

   assign w_fall = r_rx_prev & ~r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + CW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_baud_nxt = '0;
            w_bit_nxt  = '0;
            if (w_fall) w_state_nxt = RX_START;
         end
         RX_START: begin
            // A start bit that is already high again at mid-bit was a glitch.
            if (r_baud == CW'(HALF - 1)) begin
               w_baud_nxt  = '0;
               w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_baud == CW'(CLKS_PER_BIT - 1)) begin
               w_baud_nxt  = '0;
               w_shift_nxt = {r_sync2, r_shift[NUM_DATA_BITS-1:1]};
               if (r_bit == BW'(NUM_DATA_BITS - 1)) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = RX_STOP;
               end else begin
                  w_bit_nxt = r_bit + BW'(1);
               end
            end
         end
         RX_STOP: begin
            if (r_baud == CW'(CLKS_PER_BIT - 1)) begin
               w_baud_nxt  = '0;
               w_state_nxt = RX_IDLE;
               w_valid_nxt = r_sync2;
               w_ferr_nxt  = ~r_sync2;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RX_IDLE;
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
         r_baud    <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sync1   <= rx_i;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
         r_baud    <= w_baud_nxt;
         r_bit     <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_valid   <= w_valid_nxt;
         r_ferr    <= w_ferr_nxt;
      end
   end

   assign byte_o      = r_shift;
   assign valid_o     = r_valid;
   assign frame_err_o = r_ferr;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: length-prefixed UART image -> 32-bit instruction memory writes, NOOP padding.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_program_loader
   import uart_program_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = BAUD_COUNT_CHECK,
   parameter int unsigned ADDR_WIDTH   = PROGRAM_ADDRESS_WIDTH,
   parameter int unsigned WORD_WIDTH   = INSTRUCTION_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_i,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [WORD_WIDTH-1:0] imem_wdata_o,
   output logic                  cpu_rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  frame_err_o,
   output logic                  checksum_err_o
);

   localparam int unsigned WORDS = 2**(ADDR_WIDTH-2);
   localparam int unsigned IDXW  = ADDR_WIDTH - 1;
   localparam int unsigned BYTES = WORD_WIDTH / NUM_DATA_BITS;
   localparam int unsigned BIDXW = $clog2(BYTES);

   logic [NUM_DATA_BITS-1:0] w_rx_byte;
   logic                     w_rx_valid;
   logic [31:0]              w_req;
   logic [IDXW-1:0]          w_idx_inc;
   logic [WORD_WIDTH-1:0]    w_word_cat;
   logic [ADDR_WIDTH-1:0]    w_idx_addr;

   loader_state_type      r_state, w_state_nxt;
   logic [IDXW-1:0]       r_count, w_count_nxt;
   logic [IDXW-1:0]       r_idx, w_idx_nxt;
   logic [BIDXW-1:0]      r_bidx, w_bidx_nxt;
   logic [WORD_WIDTH-1:0] r_word, w_word_nxt;
   logic                  r_we, w_we_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [WORD_WIDTH-1:0] r_wdata, w_wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
   logic [NUM_DATA_BITS-1:0] r_csum, w_csum_nxt;
   logic                     r_cerr, w_cerr_nxt;
`endif

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx_i),
      .byte_o      (w_rx_byte),
      .valid_o     (w_rx_valid),
      .frame_err_o (frame_err_o)
   );

   assign w_req      = 32'(w_rx_byte);
   assign w_idx_inc  = r_idx + IDXW'(1);
   assign w_word_cat = {w_rx_byte, r_word[WORD_WIDTH-1:NUM_DATA_BITS]};
   assign w_idx_addr = {r_idx[ADDR_WIDTH-3:0], 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_idx_nxt   = r_idx;
      w_bidx_nxt  = r_bidx;
      w_word_nxt  = r_word;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
`ifdef LOADER_CHECKSUM_EN
      w_csum_nxt  = r_csum;
      w_cerr_nxt  = r_cerr;
`endif
      case (r_state)
         L_IDLE, L_DONE: begin
            if (w_rx_valid && (w_rx_byte != '0)) begin
               w_count_nxt = IDXW'((w_req > WORDS) ? WORDS : w_req);
               w_idx_nxt   = '0;
               w_bidx_nxt  = '0;
`ifdef LOADER_CHECKSUM_EN
               w_csum_nxt  = '0;
               w_cerr_nxt  = 1'b0;
`endif
               w_state_nxt = L_LOAD;
            end
         end
         L_LOAD: begin
            if (w_rx_valid) begin
               w_word_nxt = w_word_cat;
               w_bidx_nxt = r_bidx + BIDXW'(1);
`ifdef LOADER_CHECKSUM_EN
               w_csum_nxt = r_csum ^ w_rx_byte;
`endif
               if (r_bidx == BIDXW'(BYTES - 1)) begin
                  w_bidx_nxt  = '0;
                  w_we_nxt    = 1'b1;
                  w_addr_nxt  = w_idx_addr;
                  w_wdata_nxt = w_word_cat;
                  w_idx_nxt   = w_idx_inc;
                  if (w_idx_inc == r_count) begin
`ifdef LOADER_CHECKSUM_EN
                     w_state_nxt = L_CHECK;
`else
                     w_state_nxt = (w_idx_inc == IDXW'(WORDS)) ? L_DONE : L_PAD;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         L_CHECK: begin
            if (w_rx_valid) begin
               if (w_rx_byte == r_csum) begin
                  w_state_nxt = (r_idx == IDXW'(WORDS)) ? L_DONE : L_PAD;
               end else begin
                  w_cerr_nxt  = 1'b1;
                  w_state_nxt = L_IDLE;
               end
            end
         end
`endif
         L_PAD: begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = w_idx_addr;
            w_wdata_nxt = WORD_WIDTH'(NOOP);
            w_idx_nxt   = w_idx_inc;
            if (w_idx_inc == IDXW'(WORDS)) w_state_nxt = L_DONE;
         end
         default: w_state_nxt = L_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= L_IDLE;
         r_count <= '0;
         r_idx   <= '0;
         r_bidx  <= '0;
         r_word  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum  <= '0;
         r_cerr  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_idx   <= w_idx_nxt;
         r_bidx  <= w_bidx_nxt;
         r_word  <= w_word_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
         r_csum  <= w_csum_nxt;
         r_cerr  <= w_cerr_nxt;
`endif
      end
   end

   assign imem_we_o    = r_we;
   assign imem_addr_o  = r_addr;
   assign imem_wdata_o = r_wdata;
   assign cpu_rst_o    = (r_state != L_DONE);
   assign done_o       = (r_state == L_DONE);
   assign busy_o       = (r_state == L_LOAD) || (r_state == L_CHECK) || (r_state == L_PAD);
`ifdef LOADER_CHECKSUM_EN
   assign checksum_err_o = r_cerr;
`else
   assign checksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader at 16 clocks per UART bit.
module tb_uart_program_loader;

   localparam int unsigned CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_i = 1'b1;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   logic        cpu_rst_o, busy_o, done_o, frame_err_o, checksum_err_o;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  ferr_cnt = 0;
   int  rxv_cnt  = 0;

   uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_i           (rx_i),
      .imem_we_o      (imem_we_o),
      .imem_addr_o    (imem_addr_o),
      .imem_wdata_o   (imem_wdata_o),
      .cpu_rst_o      (cpu_rst_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .frame_err_o    (frame_err_o),
      .checksum_err_o (checksum_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err_o) ferr_cnt++;
         if (dut.u_rx.valid_o) rxv_cnt++;
         if (imem_we_o) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, expected no write",
                        imem_addr_o, imem_wdata_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", {24'b0, imem_addr_o}, {24'b0, mon_e.addr});
               check("wr_data", imem_wdata_o, mon_e.data);
            end
         end
      end
   end

   task automatic push_wr(input logic [7:0] addr, input logic [31:0] data);
      wr_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_pad(input int from);
      for (int k = from; k < 64; k++) push_wr(8'(k * 4), 32'h0000_0013);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = stop;
      repeat (CPB) @(negedge clk);
      rx_i = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_image(input logic [7:0] count, input logic [7:0] data[$]);
      logic [7:0] x;
      x = 8'h00;
      send_byte(count, 1'b1);
      check("busy_after_count", {31'b0, busy_o}, 32'd1);
      check("cpu_rst_after_count", {31'b0, cpu_rst_o}, 32'd1);
      check("done_after_count", {31'b0, done_o}, 32'd0);
      foreach (data[i]) begin
         send_byte(data[i], 1'b1);
         x = x ^ data[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x, 1'b1);
`endif
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (!done_o && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(name, {31'b0, done_o}, 32'd1);
      check({name, "_cpu_rst"}, {31'b0, cpu_rst_o}, 32'd0);
      check({name, "_busy"}, {31'b0, busy_o}, 32'd0);
      repeat (4) @(negedge clk);
      check({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_reset(input string name);
      check({name, "_we"}, {31'b0, imem_we_o}, 32'd0);
      check({name, "_addr"}, {24'b0, imem_addr_o}, 32'd0);
      check({name, "_wdata"}, imem_wdata_o, 32'd0);
      check({name, "_cpu_rst"}, {31'b0, cpu_rst_o}, 32'd1);
      check({name, "_busy"}, {31'b0, busy_o}, 32'd0);
      check({name, "_done"}, {31'b0, done_o}, 32'd0);
      check({name, "_ferr"}, {31'b0, frame_err_o}, 32'd0);
      check({name, "_cerr"}, {31'b0, checksum_err_o}, 32'd0);
   endtask

   initial begin
      logic [7:0] d[$];
      int f0, v0;

      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Two words then 62 NOOP pads.
      push_wr(8'h00, 32'h0010_0093);
      push_wr(8'h04, 32'h0000_0063);
      push_pad(2);
      d = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
      send_image(8'h02, d);
      wait_done("n2_done");

      // Stop bit forced low mid-word: dropped byte, word still lands at 0x00.
      push_wr(8'h00, 32'hDDCC_BBAA);
      push_pad(1);
      f0 = ferr_cnt;
      send_byte(8'h01, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b0);
      check("frame_err_pulses", 32'(ferr_cnt - f0), 32'd1);
      check("no_write_on_ferr", exp_q.size(), 32'd64);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b1);
`endif
      wait_done("ferr_done");

      // Count 0x50 saturates to 64 words, no padding.
      d = {};
      for (int i = 0; i < 256; i++) d.push_back(8'(i));
      for (int k = 0; k < 64; k++)
         push_wr(8'(k * 4), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      send_image(8'h50, d);
      wait_done("n64_done");

`ifdef LOADER_CHECKSUM_EN
      push_wr(8'h00, 32'h0000_0013);
      send_byte(8'h01, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h12, 1'b1);
      repeat (100) @(negedge clk);
      check("csum_bad_cerr", {31'b0, checksum_err_o}, 32'd1);
      check("csum_bad_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
      check("csum_bad_busy", {31'b0, busy_o}, 32'd0);
      check("csum_bad_done", {31'b0, done_o}, 32'd0);
      check("csum_bad_no_pad", exp_q.size(), 32'd0);
      push_wr(8'h00, 32'h0000_0013);
      push_pad(1);
      send_byte(8'h01, 1'b1);
      check("csum_cleared", {31'b0, checksum_err_o}, 32'd0);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      wait_done("csum_ok_done");
`endif

      // Reset after two payload bytes aborts without any write.
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Half-bit low glitch while idle must not produce a byte.
      v0 = rxv_cnt;
      f0 = ferr_cnt;
      rx_i = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rx_i = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_no_valid", 32'(rxv_cnt - v0), 32'd0);
      check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("glitch_busy", {31'b0, busy_o}, 32'd0);
      check("glitch_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);

      push_wr(8'h00, 32'h1234_5678);
      push_pad(1);
      d = '{8'h78, 8'h56, 8'h34, 8'h12};
      send_image(8'h01, d);
      wait_done("fresh_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader between the board UART pin and the core's instruction memory. It receives a length-prefixed program image over a 115200-baud 8N1 serial line, assembles little-endian bytes into 32-bit instructions, and writes them into instruction memory. It pads any unused words with NOOP and holds the core in reset until the image is complete.

## Interface
Parameters:
- CLKS_PER_BIT, default BAUD_COUNT_CHECK (868): clock cycles per UART bit.
- ADDR_WIDTH, default PROGRAM_ADDRESS_WIDTH (8): byte address width of instruction memory.
- WORD_WIDTH, default INSTRUCTION_WIDTH (32): instruction width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rx_i  in  1  asynchronous UART serial input, idle high.
- imem_we_o  out  1  instruction memory write strobe, one cycle per word.
- imem_addr_o  out  ADDR_WIDTH  byte address, always word aligned (low 2 bits 0).
- imem_wdata_o  out  WORD_WIDTH  instruction to write.
- cpu_rst_o  out  1  active-high core reset, held while loading.
- busy_o  out  1  load or pad in progress.
- done_o  out  1  image fully written, core released.
- frame_err_o  out  1  one-cycle pulse on UART stop-bit error.
- checksum_err_o  out  1  sticky checksum mismatch flag; cleared by next count byte.

## Operation
- Receiver: rx_i passes through a 2-flop synchronizer. A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if high, the frame is treated as a glitch and aborted. 8 data bits are sampled LSB first, each CLKS_PER_BIT apart, then the stop bit. Stop=1 produces a one-cycle byte valid pulse. Stop=0 discards the byte and pulses frame_err_o.
- Loader states:
  - IDLE: the next byte is the word count N. N=0 is ignored (stay IDLE). N>64 saturates to 64 (PROGRAM_WORDS). Accepting N clears the word index, byte index, checksum accumulator and checksum_err_o, then goes to LOAD.
  - LOAD: bytes are shifted in little-endian (first byte is bits 7:0). On the 4th byte, the word is written at address index*4 and the index increments. After word N, go to PAD, or to CHECK when the checksum macro is enabled.
  - CHECK: the next byte is compared to the XOR of all payload bytes. Match goes to PAD. Mismatch sets checksum_err_o and returns to IDLE with cpu_rst_o still high.
  - PAD: writes NOOP (0x13) to every remaining index up to 63, one per cycle. If N=64, no pad writes occur. Then go to DONE.
  - DONE: done_o=1 and cpu_rst_o=0. A new nonzero count byte restarts a load: cpu_rst_o rises and done_o falls in the same cycle.
- busy_o is high in LOAD, CHECK and PAD.
- Word index width is ADDR_WIDTH-2 plus one carry bit; it never wraps into address 0.
- A frame error in LOAD or CHECK does not advance any counter; the loader waits for a valid byte.

## Timing
- Reset values: imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, frame_err_o=0, checksum_err_o=0. Loader enters IDLE and receiver enters RX_IDLE.
- Byte valid pulses at mid-stop-bit plus 2 cycles of synchronizer latency.
- imem_we_o, imem_addr_o and imem_wdata_o are registered. They are valid the cycle after the 4th byte valid, and imem_we_o lasts exactly one cycle.
- PAD issues one write per cycle back to back. DONE (cpu_rst_o falling) is entered the cycle after the last pad write, or the cycle after the last LOAD/CHECK write when N=64.
- rst asserted mid-frame or mid-load aborts immediately. The next cycle shows reset values, and partial memory contents are not cleared.

## Configuration
- LOADER_CHECKSUM_EN defined: CHECK state exists; the host sends one XOR checksum byte after the payload.
- LOADER_CHECKSUM_EN undefined: LOAD goes directly to PAD, no checksum byte is expected, and checksum_err_o is tied 0.

## Structure
- Shared package gains:
  - PROGRAM_WORDS = 2**(PROGRAM_ADDRESS_WIDTH-2).
  - loader_state_type {L_IDLE, L_LOAD, L_CHECK, L_PAD, L_DONE}.
  - uart_rx_state_type {RX_IDLE, RX_START, RX_DATA, RX_STOP}.
  - The loader reuses NOOP, BAUD_COUNT_CHECK and NUM_DATA_BITS from the package.
- Sub-module uart_rx (synchronizer, bit counter, baud counter, byte_o, valid_o, frame_err_o) is instantiated once; the loader FSM stays in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Count 0x02, then bytes 93 00 10 00 63 00 00 00 -> writes 0x00100093 @0x00 and 0x00000063 @0x04, then 62 NOOP writes @0x08..0xFC, then done_o=1 and cpu_rst_o=0.
- Count 0x50 followed by 256 bytes -> saturates to 64 words, no pad writes, last write @0xFC.
- Byte with stop bit forced 0 during LOAD -> frame_err_o pulses once, no write, and the next valid bytes complete the word at the correct address.
- With LOADER_CHECKSUM_EN: count 0x01, then 13 00 00 00, then checksum 0x12 -> checksum_err_o=1, state IDLE, cpu_rst_o=1, no pad writes. Checksum 0x13 -> pad and done.
- rst pulsed after 2 payload bytes -> all outputs at reset values. A fresh image then loads correctly from address 0.
- 0.5-bit low glitch on rx_i while IDLE -> no byte valid, no state change.
